led_scanner: RTL and testbench

Parametrised successor of the fixed 10-LED Knight-Rider scanner. Drives a lit "head" LED with an optional trailing tail across an NUM_LEDS-wide bar. The bar runs in bounce, rotate-left, rotate-right or hold mode. Sits directly between CLOCK_50 and the board LEDR bus. It steps on a single-cycle clock-enable tick and never uses a derived clock.

---
 rtl/led_scanner_pkg.sv | 17 +
 rtl/led_scanner_if.sv | 26 ++
 rtl/tick_prescaler.sv | 29 ++
 rtl/led_scanner.sv | 109 ++++++++++
 tb/tb_led_scanner.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/led_scanner_pkg.sv
// Shared encodings and sizing helpers for the LED bar scanner and its prescaler.
package led_scanner_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_ROT_L  = 2'd1;
    localparam logic [1:0] MODE_ROT_R  = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Counter/index width that never collapses to zero bits for n <= 1.
    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_scanner_if.sv
// Control and display bundle between the board-level driver and the scanner core.
interface led_scanner_if
    import led_scanner_pkg::*;
#(
    parameter int NUM_LEDS = 10
);
    localparam int POS_W = min1_clog2(NUM_LEDS);

    logic                enable;
    logic [1:0]          mode;
    logic [NUM_LEDS-1:0] LEDR;
    logic [POS_W-1:0]    pos;
    logic                dir;
    logic                step_pulse;

    modport master (
        output enable, mode,
        input  LEDR, pos, dir, step_pulse
    );

    modport slave (
        input  enable, mode,
        output LEDR, pos, dir, step_pulse
    );

endinterface

// File: rtl/tick_prescaler.sv
// Single-cycle clock-enable generator: one tick every TICK_DIV cycles while run is high.
module tick_prescaler
    import led_scanner_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic run,
    output logic tick
);
    localparam int                CNT_W    = min1_clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = run && (cnt_q == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (!run || tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/led_scanner.sv
// Knight-Rider style LED bar scanner: moving head with optional tail in bounce/rotate/hold modes.
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int NUM_LEDS = 10,
    parameter int TICK_DIV = 4,
    parameter int TAIL_LEN = 1
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    led_scanner_if.slave  bus
);
    localparam int                  POS_W    = min1_clog2(NUM_LEDS);
    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);

    logic             run;
    logic             tick;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_q;
    logic             wrap_q;

    assign run = bus.enable && (bus.mode != MODE_HOLD);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .run      (run),
        .tick     (tick)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        case (bus.mode)
            MODE_BOUNCE: begin
                if (dir_q == DIR_UP) begin
                    if (pos_q == POS_LAST) begin
                        pos_d = POS_LAST - 1'b1;
                        dir_d = DIR_DOWN;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_d = POS_W'(1);
                        dir_d = DIR_UP;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end
            MODE_ROT_L: begin
                dir_d = DIR_UP;
                pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
            end
            MODE_ROT_R: begin
                dir_d = DIR_DOWN;
                pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
            end
            default: ;
        endcase
    end

    // wrap_q remembers whether the last step was a rotate step, so tail wrapping follows the sampled mode.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pos_q  <= '0;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            step_q <= tick;
            if (tick) begin
                pos_q  <= pos_d;
                dir_q  <= dir_d;
                wrap_q <= (bus.mode == MODE_ROT_L) || (bus.mode == MODE_ROT_R);
            end
        end
    end

    // Tail bits trail behind the head; outside the bar they wrap in rotate modes, else are dropped.
    always_comb begin
        int  idx;
        logic wrap_en;
        wrap_en  = wrap_q && (bus.mode != MODE_HOLD);
        bus.LEDR = LED_ONE << pos_q;
        for (int k = 1; k < TAIL_LEN; k++) begin
            idx = (dir_q == DIR_UP) ? int'(pos_q) - k : int'(pos_q) + k;
            if (idx >= 0 && idx < NUM_LEDS)
                bus.LEDR = bus.LEDR | (LED_ONE << unsigned'(idx));
            else if (wrap_en && idx < 0)
                bus.LEDR = bus.LEDR | (LED_ONE << unsigned'(idx + NUM_LEDS));
            else if (wrap_en)
                bus.LEDR = bus.LEDR | (LED_ONE << unsigned'(idx - NUM_LEDS));
        end
    end

    assign bus.pos        = pos_q;
    assign bus.dir        = dir_q;
    assign bus.step_pulse = step_q;

    pos_in_range: assert property (@(posedge CLOCK_50) disable iff (reset) pos_q <= POS_LAST);

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench: default scanner for bounce/freeze/reset, TAIL_LEN=3 TICK_DIV=1 scanner for tails and rotation.
module tb_led_scanner;

    logic CLOCK_50 = 1'b0;
    logic rst0, rst1;

    always #5 CLOCK_50 = ~CLOCK_50;

    led_scanner_if #(.NUM_LEDS(10)) bus0 ();
    led_scanner_if #(.NUM_LEDS(10)) bus1 ();

    led_scanner #(.NUM_LEDS(10), .TICK_DIV(4), .TAIL_LEN(1)) u0 (
        .CLOCK_50 (CLOCK_50),
        .reset    (rst0),
        .bus      (bus0)
    );

    led_scanner #(.NUM_LEDS(10), .TICK_DIV(1), .TAIL_LEN(3)) u1 (
        .CLOCK_50 (CLOCK_50),
        .reset    (rst1),
        .bus      (bus1)
    );

    typedef struct {
        int         pos;
        logic       dir;
        logic [9:0] ledr;
    } step_vec_t;

    typedef struct {
        logic [1:0] mode;
        logic       sp;
        int         pos;
        logic       dir;
        logic [9:0] ledr;
    } cyc_vec_t;

    step_vec_t bounce_tbl[20];
    cyc_vec_t  tail_tbl[27];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Runs n bounce steps on u0 from bounce_tbl, checking step_pulse on every cycle.
    task automatic run_bounce0(input int n);
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge CLOCK_50);
                check("u0 step_pulse", 32'(bus0.step_pulse), 32'(c == 3));
            end
            check("u0 pos",  32'(bus0.pos),  32'(bounce_tbl[s].pos));
            check("u0 dir",  32'(bus0.dir),  32'(bounce_tbl[s].dir));
            check("u0 LEDR", 32'(bus0.LEDR), 32'(bounce_tbl[s].ledr));
        end
    endtask

    // Freezes u0 for 10 cycles two counts into a step, then expects the next step exactly 4 cycles after resume.
    task automatic freeze0(input logic use_hold, input int pos_now, input int pos_next);
        repeat (2) @(negedge CLOCK_50);
        if (use_hold) bus0.mode = 2'd3;
        else          bus0.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            check("frozen pos",        32'(bus0.pos),        32'(pos_now));
            check("frozen LEDR",       32'(bus0.LEDR),       32'(10'h001 << pos_now));
            check("frozen step_pulse", 32'(bus0.step_pulse), 32'(0));
        end
        bus0.mode   = 2'd0;
        bus0.enable = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLOCK_50);
            check("resume step_pulse", 32'(bus0.step_pulse), 32'(c == 3));
        end
        check("resume pos",  32'(bus0.pos),  32'(pos_next));
        check("resume LEDR", 32'(bus0.LEDR), 32'(10'h001 << pos_next));
    endtask

    initial begin
        bounce_tbl[0]  = '{1, 1'b1, 10'h002};
        bounce_tbl[1]  = '{2, 1'b1, 10'h004};
        bounce_tbl[2]  = '{3, 1'b1, 10'h008};
        bounce_tbl[3]  = '{4, 1'b1, 10'h010};
        bounce_tbl[4]  = '{5, 1'b1, 10'h020};
        bounce_tbl[5]  = '{6, 1'b1, 10'h040};
        bounce_tbl[6]  = '{7, 1'b1, 10'h080};
        bounce_tbl[7]  = '{8, 1'b1, 10'h100};
        bounce_tbl[8]  = '{9, 1'b1, 10'h200};
        bounce_tbl[9]  = '{8, 1'b0, 10'h100};
        bounce_tbl[10] = '{7, 1'b0, 10'h080};
        bounce_tbl[11] = '{6, 1'b0, 10'h040};
        bounce_tbl[12] = '{5, 1'b0, 10'h020};
        bounce_tbl[13] = '{4, 1'b0, 10'h010};
        bounce_tbl[14] = '{3, 1'b0, 10'h008};
        bounce_tbl[15] = '{2, 1'b0, 10'h004};
        bounce_tbl[16] = '{1, 1'b0, 10'h002};
        bounce_tbl[17] = '{0, 1'b0, 10'h001};
        bounce_tbl[18] = '{1, 1'b1, 10'h002};
        bounce_tbl[19] = '{2, 1'b1, 10'h004};

        tail_tbl[0]  = '{2'd0, 1'b1, 1, 1'b1, 10'h003};
        tail_tbl[1]  = '{2'd0, 1'b1, 2, 1'b1, 10'h007};
        tail_tbl[2]  = '{2'd0, 1'b1, 3, 1'b1, 10'h00E};
        tail_tbl[3]  = '{2'd0, 1'b1, 4, 1'b1, 10'h01C};
        tail_tbl[4]  = '{2'd0, 1'b1, 5, 1'b1, 10'h038};
        tail_tbl[5]  = '{2'd0, 1'b1, 6, 1'b1, 10'h070};
        tail_tbl[6]  = '{2'd0, 1'b1, 7, 1'b1, 10'h0E0};
        tail_tbl[7]  = '{2'd0, 1'b1, 8, 1'b1, 10'h1C0};
        tail_tbl[8]  = '{2'd0, 1'b1, 9, 1'b1, 10'h380};
        tail_tbl[9]  = '{2'd0, 1'b1, 8, 1'b0, 10'h300};
        tail_tbl[10] = '{2'd2, 1'b1, 7, 1'b0, 10'h380};
        tail_tbl[11] = '{2'd2, 1'b1, 6, 1'b0, 10'h1C0};
        tail_tbl[12] = '{2'd2, 1'b1, 5, 1'b0, 10'h0E0};
        tail_tbl[13] = '{2'd2, 1'b1, 4, 1'b0, 10'h070};
        tail_tbl[14] = '{2'd2, 1'b1, 3, 1'b0, 10'h038};
        tail_tbl[15] = '{2'd2, 1'b1, 2, 1'b0, 10'h01C};
        tail_tbl[16] = '{2'd2, 1'b1, 1, 1'b0, 10'h00E};
        tail_tbl[17] = '{2'd2, 1'b1, 0, 1'b0, 10'h007};
        tail_tbl[18] = '{2'd2, 1'b1, 9, 1'b0, 10'h203};
        tail_tbl[19] = '{2'd2, 1'b1, 8, 1'b0, 10'h301};
        tail_tbl[20] = '{2'd1, 1'b1, 9, 1'b1, 10'h380};
        tail_tbl[21] = '{2'd1, 1'b1, 0, 1'b1, 10'h301};
        tail_tbl[22] = '{2'd1, 1'b1, 1, 1'b1, 10'h203};
        tail_tbl[23] = '{2'd1, 1'b1, 2, 1'b1, 10'h007};
        tail_tbl[24] = '{2'd0, 1'b1, 3, 1'b1, 10'h00E};
        tail_tbl[25] = '{2'd3, 1'b0, 3, 1'b1, 10'h00E};
        tail_tbl[26] = '{2'd0, 1'b1, 4, 1'b1, 10'h01C};

        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.enable = 1'b0;
        bus0.mode   = 2'd0;
        bus1.enable = 1'b0;
        bus1.mode   = 2'd0;
        repeat (3) @(negedge CLOCK_50);

        check("reset pos",        32'(bus0.pos),        32'(0));
        check("reset dir",        32'(bus0.dir),        32'(1));
        check("reset LEDR",       32'(bus0.LEDR),       32'(10'h001));
        check("reset step_pulse", 32'(bus0.step_pulse), 32'(0));

        bus0.enable = 1'b1;
        rst0 = 1'b0;
        run_bounce0(20);

        freeze0(1'b0, 2, 3);
        freeze0(1'b1, 3, 4);

        // Eight more steps from pos 4 up: 5,6,7,8,9,8,7,6 leaves pos 6 heading down.
        repeat (32) @(negedge CLOCK_50);
        check("pre-reset pos", 32'(bus0.pos), 32'(6));
        check("pre-reset dir", 32'(bus0.dir), 32'(0));

        #2 rst0 = 1'b1;
        #1;
        check("async reset pos",        32'(bus0.pos),        32'(0));
        check("async reset dir",        32'(bus0.dir),        32'(1));
        check("async reset LEDR",       32'(bus0.LEDR),       32'(10'h001));
        check("async reset step_pulse", 32'(bus0.step_pulse), 32'(0));
        repeat (2) @(negedge CLOCK_50);
        check("held reset pos", 32'(bus0.pos), 32'(0));
        rst0 = 1'b0;
        run_bounce0(5);

        bus1.enable = 1'b1;
        rst1 = 1'b0;
        for (int i = 0; i < 27; i++) begin
            bus1.mode = tail_tbl[i].mode;
            @(negedge CLOCK_50);
            check($sformatf("u1[%0d] step_pulse", i), 32'(bus1.step_pulse), 32'(tail_tbl[i].sp));
            check($sformatf("u1[%0d] pos", i),        32'(bus1.pos),        32'(tail_tbl[i].pos));
            check($sformatf("u1[%0d] dir", i),        32'(bus1.dir),        32'(tail_tbl[i].dir));
            check($sformatf("u1[%0d] LEDR", i),       32'(bus1.LEDR),       32'(tail_tbl[i].ledr));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
